pc_next_unit: RTL and testbench
===============================

# pc_next_unit

Program-counter register and redirect controller for the IF stage. Consumes the JR/JALR flags from the JR control decoder and the branch/jump decisions from decode, then selects the next PC. Flushes the wrong-path instruction in IF/ID and returns the JAL/JALR link address to the register-file write path. Also keeps a saturating redirect counter for the debug unit.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- CNT_WIDTH, 16, width of the redirect counter

Ports:
- i_clk  in  1  single clock, rising edge
- i_reset  in  1  synchronous, active-high reset
- i_enable  in  1  debug-unit run/step enable; 0 freezes all state
- i_stall  in  1  hazard-unit stall; holds PC and blocks redirects
- i_halt  in  1  decode saw HALT; PC freezes until reset
- i_jr  in  1  JR control flag (asserted for both JR and JALR)
- i_jalr  in  1  JALR control flag
- i_rs_data  in  32  forwarded rs value, used as the JR/JALR target
- i_jump  in  1  J/JAL in decode
- i_jal  in  1  JAL in decode; qualifies i_jump
- i_instr_index  in  26  J-type instr_index field
- i_branch_taken  in  1  resolved taken branch in decode
- i_branch_target  in  32  branch target address
- i_id_pc_plus4  in  32  PC+4 of the instruction in decode
- o_pc  out  32  current fetch address
- o_pc_plus4  out  32  o_pc + 4, combinational
- o_flush  out  1  squash IF/ID this cycle, combinational
- o_link_we  out  1  link write strobe, one cycle
- o_link_addr  out  32  link value
- o_halted  out  1  halted state indicator
- o_misaligned  out  1  sticky misaligned-target flag (macro-dependent)
- o_redirect_count  out  CNT_WIDTH  number of accepted redirects, saturating

## Operation
- FSM states:
  - RUN: normal fetch.
  - SHADOW: the single cycle after a redirect.
  - HALTED: PC frozen.
- Reset has top priority over everything: state RUN, o_pc=RESET_PC, o_link_we=0, o_link_addr=0, o_halted=0, o_misaligned=0, o_redirect_count=0.
- Effective advance: adv = i_enable & ~i_stall & state!=HALTED. When adv=0, all registers hold and o_flush=0.
- Redirect source priority: JR > jump > branch > sequential.
  - JR target: i_rs_data.
  - Jump target: {i_id_pc_plus4[31:28], i_instr_index, 2'b00}.
  - Branch target: i_branch_target.
- In RUN with adv=1 and any redirect source active:
  - o_pc <= target, o_flush=1 this cycle, state -> SHADOW.
  - Counter increments, saturating at all-ones.
- In SHADOW: redirect inputs are ignored (decode holds a bubble). o_pc <= o_pc+4 when adv=1, then state -> RUN. A stall in SHADOW keeps the FSM in SHADOW.
- Link write: on an accepted JALR, or JAL (i_jump & i_jal), o_link_we <= 1 and o_link_addr <= i_id_pc_plus4. Otherwise o_link_we <= 0. No delay slot.
- i_jalr without i_jr is illegal. Treat it as no redirect and no link.
- Halt: i_halt with adv=1 in RUN sends the state to HALTED and holds o_pc. If i_halt and a redirect arrive together, the halt wins. HALTED exits only through reset.
- PC arithmetic is modulo 2^32. 32'hFFFF_FFFC + 4 wraps to 0 with no flag.

## Timing
- The PC register updates one edge after a decision. o_flush is valid in the same cycle as the redirect inputs.
- Redirect-to-new-fetch latency: 1 cycle. The wrong-path slot costs exactly 1 bubble.
- o_link_we is high for exactly one cycle, the cycle after acceptance.
- If reset is asserted mid-redirect (including in SHADOW), the next cycle is RUN at RESET_PC with no pending flush or link.
- o_redirect_count is readable the cycle after the increment.

## Configuration
- PC_ALIGN_CHECK_EN:
  - Defined: a JR/JALR target with i_rs_data[1:0]!=0 is not accepted. PC holds, o_flush=0, no link write. o_misaligned sets and stays set until reset, and the state moves to HALTED.
  - Undefined: target[1:0] is forced to 2'b00, and o_misaligned is tied to 0.

## Structure
- Shared package mips_pkg holds:
  - FSM state typedef (RUN, SHADOW, HALTED).
  - Redirect-source enum (SRC_SEQ, SRC_BRANCH, SRC_JUMP, SRC_JR).
  - Constant PC_INCR = 4.
- Sub-module pc_target_mux: combinational priority select and jump-target concatenation.
- FSM, PC register, link register and counter live in pc_next_unit.

## Test plan
- Reset then 3 free-running cycles -> o_pc = 0, 4, 8, 12; o_flush=0; counter=0.
- JR with i_rs_data=32'h40 while o_pc=16 -> o_flush=1 that cycle, o_pc=32'h40 next, counter=1, no link write.
- JALR with rs=32'h100, id_pc_plus4=32'h24 -> o_pc=32'h100, o_link_we pulse one cycle, o_link_addr=32'h24.
- JR and branch together, i_stall=1 for 2 cycles, then released -> PC held while stalled; after release o_pc=rs target (JR wins); one flush only.
- Redirect, then a second redirect presented in SHADOW -> second one ignored, o_pc = target+4.
- With PC_ALIGN_CHECK_EN defined, JR to 32'h42 -> o_misaligned=1, o_halted=1, o_pc unchanged; without the macro -> o_pc=32'h40.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared IF-stage definitions: FSM state encoding, redirect-source enum and
// the sequential PC increment.
package mips_pkg;

    typedef logic [1:0] pc_state_t;

    localparam pc_state_t ST_RUN    = 2'd0;
    localparam pc_state_t ST_SHADOW = 2'd1;
    localparam pc_state_t ST_HALTED = 2'd2;

    typedef enum logic [1:0] {
        SRC_SEQ    = 2'd0,
        SRC_BRANCH = 2'd1,
        SRC_JUMP   = 2'd2,
        SRC_JR     = 2'd3
    } redirect_src_e;

    localparam logic [31:0] PC_INCR = 32'd4;

endpackage

// File: rtl/pc_target_mux.sv
// Combinational redirect-source priority select (JR > jump > branch > sequential)
// and J-type target formation.
module pc_target_mux
    import mips_pkg::*;
(
    input  logic          i_jr,
    input  logic [31:0]   i_rs_data,
    input  logic          i_jump,
    input  logic [25:0]   i_instr_index,
    input  logic          i_branch_taken,
    input  logic [31:0]   i_branch_target,
    input  logic [31:0]   i_id_pc_plus4,
    input  logic [31:0]   i_seq_pc,
    output redirect_src_e o_src,
    output logic [31:0]   o_target
);

    always_comb begin
        o_src    = SRC_SEQ;
        o_target = i_seq_pc;
        if (i_jr) begin
            o_src    = SRC_JR;
            o_target = i_rs_data;
        end else if (i_jump) begin
            o_src    = SRC_JUMP;
            o_target = {i_id_pc_plus4[31:28], i_instr_index, 2'b00};
        end else if (i_branch_taken) begin
            o_src    = SRC_BRANCH;
            o_target = i_branch_target;
        end
    end

endmodule

// File: rtl/pc_next_unit.sv
// IF-stage PC register, redirect FSM, link-address return and redirect counter.
// Optional macro PC_ALIGN_CHECK_EN: misaligned JR/JALR targets halt instead of being truncated.
module pc_next_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          CNT_WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_enable,
    input  logic                 i_stall,
    input  logic                 i_halt,
    input  logic                 i_jr,
    input  logic                 i_jalr,
    input  logic [31:0]          i_rs_data,
    input  logic                 i_jump,
    input  logic                 i_jal,
    input  logic [25:0]          i_instr_index,
    input  logic                 i_branch_taken,
    input  logic [31:0]          i_branch_target,
    input  logic [31:0]          i_id_pc_plus4,
    output logic [31:0]          o_pc,
    output logic [31:0]          o_pc_plus4,
    output logic                 o_flush,
    output logic                 o_link_we,
    output logic [31:0]          o_link_addr,
    output logic                 o_halted,
    output logic                 o_misaligned,
    output logic [CNT_WIDTH-1:0] o_redirect_count
);

    pc_state_t              state_q, state_d;
    logic [31:0]            pc_q, pc_d;
    logic                   link_we_q, link_we_d;
    logic [31:0]            link_addr_q, link_addr_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [31:0]            pc_plus4;
    logic [31:0]            mux_target;
    logic [31:0]            target;
    redirect_src_e          src;
    logic                   adv;
    logic                   flush;

    pc_target_mux u_target_mux (
        .i_jr            (i_jr),
        .i_rs_data       (i_rs_data),
        .i_jump          (i_jump),
        .i_instr_index   (i_instr_index),
        .i_branch_taken  (i_branch_taken),
        .i_branch_target (i_branch_target),
        .i_id_pc_plus4   (i_id_pc_plus4),
        .i_seq_pc        (pc_plus4),
        .o_src           (src),
        .o_target        (mux_target)
    );

`ifdef PC_ALIGN_CHECK_EN
    logic misaligned_q, misaligned_d;
    logic misalign;
    assign target   = mux_target;
    assign misalign = (src == SRC_JR) && (i_rs_data[1:0] != 2'b00);
`else
    assign target = {mux_target[31:2], 2'b00};
`endif

    always_comb begin
        pc_plus4    = pc_q + PC_INCR;
        adv         = i_enable & ~i_stall & (state_q != ST_HALTED);
        state_d     = state_q;
        pc_d        = pc_q;
        link_we_d   = 1'b0;
        link_addr_d = link_addr_q;
        cnt_d       = cnt_q;
        flush       = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
        misaligned_d = misaligned_q;
`endif
        case (state_q)
            ST_RUN: begin
                if (adv) begin
                    if (i_halt) begin
                        state_d = ST_HALTED;
`ifdef PC_ALIGN_CHECK_EN
                    end else if (misalign) begin
                        misaligned_d = 1'b1;
                        state_d      = ST_HALTED;
`endif
                    end else if (src != SRC_SEQ) begin
                        pc_d    = target;
                        flush   = 1'b1;
                        state_d = ST_SHADOW;
                        if (cnt_q != {CNT_WIDTH{1'b1}}) begin
                            cnt_d = cnt_q + CNT_WIDTH'(1);
                        end
                        // JALR only links when it also carries the JR flag (src is JR)
                        link_we_d = ((src == SRC_JR) & i_jalr) | ((src == SRC_JUMP) & i_jal);
                        if (link_we_d) begin
                            link_addr_d = i_id_pc_plus4;
                        end
                    end else begin
                        pc_d = pc_plus4;
                    end
                end
            end
            ST_SHADOW: begin
                // Decode holds a bubble here, so redirect inputs are not looked at
                if (adv) begin
                    pc_d    = pc_plus4;
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= ST_RUN;
            pc_q        <= RESET_PC;
            link_we_q   <= 1'b0;
            link_addr_q <= 32'h0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            link_we_q   <= link_we_d;
            link_addr_q <= link_addr_d;
            cnt_q       <= cnt_d;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= misaligned_d;
        end
    end
    assign o_misaligned = misaligned_q;
`else
    assign o_misaligned = 1'b0;
`endif

    assign o_pc             = pc_q;
    assign o_pc_plus4       = pc_plus4;
    assign o_flush          = flush & ~i_reset;
    assign o_link_we        = link_we_q;
    assign o_link_addr      = link_addr_q;
    assign o_halted         = (state_q == ST_HALTED);
    assign o_redirect_count = cnt_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed bench for pc_next_unit: expected PCs are queued as each cycle is
// driven and popped/compared after the clock edge.
module tb_pc_next_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        en, stall, halt, jr, jalr, jump, jal, br;
    logic [31:0] rs, br_tgt, id_pc4;
    logic [25:0] idx;
    logic [31:0] pc, pc4, link_addr;
    logic        flush, link_we, halted, misaligned;
    logic [15:0] cnt;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    pc_next_unit #(.RESET_PC(32'h0), .CNT_WIDTH(16)) dut (
        .i_clk(clk), .i_reset(rst), .i_enable(en), .i_stall(stall), .i_halt(halt),
        .i_jr(jr), .i_jalr(jalr), .i_rs_data(rs), .i_jump(jump), .i_jal(jal),
        .i_instr_index(idx), .i_branch_taken(br), .i_branch_target(br_tgt),
        .i_id_pc_plus4(id_pc4), .o_pc(pc), .o_pc_plus4(pc4), .o_flush(flush),
        .o_link_we(link_we), .o_link_addr(link_addr), .o_halted(halted),
        .o_misaligned(misaligned), .o_redirect_count(cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic idle();
        en = 1'b1; stall = 1'b0; halt = 1'b0; jr = 1'b0; jalr = 1'b0;
        jump = 1'b0; jal = 1'b0; br = 1'b0; rs = '0; br_tgt = '0; id_pc4 = '0; idx = '0;
    endtask

    // Inputs are already driven; check flush now, then compare the queued PC after the edge
    task automatic cycle(input string tag, input logic [31:0] exp_pc, input logic exp_flush);
        exp_q.push_back(exp_pc);
        #1;
        chk({tag, "_flush"}, {31'b0, flush}, {31'b0, exp_flush});
        @(posedge clk);
        #1;
        chk({tag, "_pc"}, pc, exp_q.pop_front());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_pc", pc, 32'h0);
        chk("rst_link_we", {31'b0, link_we}, 32'h0);
        chk("rst_link_addr", link_addr, 32'h0);
        chk("rst_halted", {31'b0, halted}, 32'h0);
        chk("rst_misaligned", {31'b0, misaligned}, 32'h0);
        chk("rst_cnt", {16'b0, cnt}, 32'h0);
        chk("rst_pc4", pc4, 32'h4);

        cycle("seq1", 32'h4, 1'b0);
        cycle("seq2", 32'h8, 1'b0);
        cycle("seq3", 32'hC, 1'b0);
        cycle("seq4", 32'h10, 1'b0);

        jr = 1'b1; rs = 32'h40;
        cycle("jr", 32'h40, 1'b1);
        chk("jr_cnt", {16'b0, cnt}, 32'd1);
        chk("jr_link_we", {31'b0, link_we}, 32'h0);
        idle();
        cycle("jr_shadow", 32'h44, 1'b0);

        jr = 1'b1; jalr = 1'b1; rs = 32'h100; id_pc4 = 32'h24;
        cycle("jalr", 32'h100, 1'b1);
        chk("jalr_link_we", {31'b0, link_we}, 32'h1);
        chk("jalr_link_addr", link_addr, 32'h24);
        chk("jalr_cnt", {16'b0, cnt}, 32'd2);
        idle();
        cycle("jalr_shadow", 32'h104, 1'b0);
        chk("jalr_link_we_off", {31'b0, link_we}, 32'h0);
        chk("jalr_link_addr_hold", link_addr, 32'h24);

        jr = 1'b1; rs = 32'h200; br = 1'b1; br_tgt = 32'h300; stall = 1'b1;
        cycle("stall1", 32'h104, 1'b0);
        cycle("stall2", 32'h104, 1'b0);
        chk("stall_cnt", {16'b0, cnt}, 32'd2);
        stall = 1'b0;
        cycle("stall_rel", 32'h200, 1'b1);
        chk("stall_rel_cnt", {16'b0, cnt}, 32'd3);

        idle(); br = 1'b1; br_tgt = 32'h500;
        cycle("shadow_ignore", 32'h204, 1'b0);
        chk("shadow_ignore_cnt", {16'b0, cnt}, 32'd3);

        idle(); jump = 1'b1; jal = 1'b1; idx = 26'h10; id_pc4 = 32'h1000_0008;
        cycle("jal", 32'h1000_0040, 1'b1);
        chk("jal_link_we", {31'b0, link_we}, 32'h1);
        chk("jal_link_addr", link_addr, 32'h1000_0008);
        idle();
        cycle("jal_shadow", 32'h1000_0044, 1'b0);

        jalr = 1'b1; rs = 32'h800;
        cycle("bad_jalr", 32'h1000_0048, 1'b0);
        chk("bad_jalr_link_we", {31'b0, link_we}, 32'h0);
        idle(); en = 1'b0; br = 1'b1; br_tgt = 32'h900;
        cycle("disabled", 32'h1000_0048, 1'b0);

        idle(); jr = 1'b1; rs = 32'hFFFF_FFFC;
        cycle("wrap_jr", 32'hFFFF_FFFC, 1'b1);
        idle();
        cycle("wrap_seq", 32'h0, 1'b0);
        chk("wrap_cnt", {16'b0, cnt}, 32'd5);

        jr = 1'b1; rs = 32'h42;
`ifdef PC_ALIGN_CHECK_EN
        cycle("misalign", 32'h0, 1'b0);
        chk("misalign_flag", {31'b0, misaligned}, 32'h1);
        chk("misalign_halted", {31'b0, halted}, 32'h1);
        chk("misalign_cnt", {16'b0, cnt}, 32'd5);
        idle();
        cycle("halted_hold", 32'h0, 1'b0);
`else
        cycle("trunc_jr", 32'h40, 1'b1);
        chk("trunc_misaligned", {31'b0, misaligned}, 32'h0);
        chk("trunc_cnt", {16'b0, cnt}, 32'd6);
        idle();
        cycle("trunc_shadow", 32'h44, 1'b0);
        halt = 1'b1; jr = 1'b1; rs = 32'h600;
        cycle("halt_wins", 32'h44, 1'b0);
        chk("halt_halted", {31'b0, halted}, 32'h1);
        chk("halt_cnt", {16'b0, cnt}, 32'd6);
        idle(); br = 1'b1; br_tgt = 32'h700;
        cycle("halted_hold", 32'h44, 1'b0);
`endif

        idle(); rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst2_pc", pc, 32'h0);
        chk("rst2_halted", {31'b0, halted}, 32'h0);
        chk("rst2_misaligned", {31'b0, misaligned}, 32'h0);
        chk("rst2_cnt", {16'b0, cnt}, 32'h0);

        jr = 1'b1; jalr = 1'b1; rs = 32'h80; id_pc4 = 32'h14;
        cycle("pre_rst_jalr", 32'h80, 1'b1);
        idle(); rst = 1'b1;
        cycle("rst_in_shadow", 32'h0, 1'b0);
        rst = 1'b0;
        chk("rst_shadow_link_we", {31'b0, link_we}, 32'h0);
        chk("rst_shadow_link_addr", link_addr, 32'h0);
        chk("rst_shadow_cnt", {16'b0, cnt}, 32'h0);
        cycle("post_rst_seq", 32'h4, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
